// File: rtl/ysyx_23060208_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// bus response codes and default geometry.
package ysyx_23060208_fetch_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int INST_STEP_DEF  = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_UPD  = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_HOLD = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/ysyx_23060208_fetch_ctrl.sv
// Instruction-fetch sequencer: drives the PC register write port, issues one read per
// instruction and hands the word to the IDU. Perf counters: YSYX_23060208_FETCH_PERF_EN.
module ysyx_23060208_fetch_ctrl
  import ysyx_23060208_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int INST_STEP  = INST_STEP_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_wen,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [DATA_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  fetch_err,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt,
  output fetch_state_e          dbg_state
);

  // Handshake rule: a transfer happens on a rising clock edge where both valid and
  // ready are high; valid and its payload stay stable until that edge.
  fetch_state_e          state_q, state_d;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_pc;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] inst_pc_q;
  logic                  err_q;
  logic                  rsp_ok;

  assign rsp_ok = (rresp == RESP_OKAY);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UPD:  state_d = ST_ADDR;
      ST_ADDR: if (arready) state_d = ST_DATA;
      ST_DATA: begin
        if (rvalid) begin
          if (!rsp_ok)                          state_d = ST_ERR;
          else if (pend_valid || redirect_valid) state_d = ST_UPD;
          else                                  state_d = ST_HOLD;
        end
      end
      ST_HOLD: if (inst_ready || redirect_valid) state_d = ST_UPD;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_UPD;
    endcase
  end

  // A redirect seen outside UPD is only a one-cycle pulse, so it is parked in pend_pc
  // until the next UPD writes it into the PC register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_UPD;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_UPD) begin
        pend_valid <= 1'b0;
      end else if (state_q != ST_ERR && redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
      if (state_q == ST_DATA && rvalid) begin
        if (!rsp_ok) begin
          err_q <= 1'b1;
        end else if (!pend_valid && !redirect_valid) begin
          inst_q    <= rdata;
          inst_pc_q <= pc;
        end
      end
    end
  end

  assign pc_wen     = (state_q == ST_UPD);
  assign arvalid    = (state_q == ST_ADDR);
  assign rready     = (state_q == ST_DATA);
  assign inst_valid = (state_q == ST_HOLD);
  assign araddr     = pc;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = err_q;
  assign dbg_state  = state_q;

  always_comb begin
    next_pc = pc + DATA_WIDTH'(INST_STEP);
    if (redirect_valid)  next_pc = redirect_pc;
    else if (pend_valid) next_pc = pend_pc;
  end

`ifdef YSYX_23060208_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (inst_valid && inst_ready)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (inst_valid && !inst_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060208_fetch_ctrl.sv
// Bench for the fetch sequencer: cycle-by-cycle vector table plus hand-written
// reset sequences; includes a model of the PC register the block drives.
module tb_ysyx_23060208_fetch_ctrl;
  import ysyx_23060208_fetch_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  pc;
  logic         pc_wen;
  logic [31:0]  next_pc;
  logic         arvalid;
  logic         arready;
  logic [31:0]  araddr;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         fetch_err;
  logic [31:0]  fetch_cnt;
  logic [31:0]  stall_cnt;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060208_fetch_ctrl dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_wen(pc_wen), .next_pc(next_pc),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset block and PC register model
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset)       pc <= 32'h7FFF_FFFC;
    else if (pc_wen) pc <= next_pc;
  end

  // flags = {pc_wen, arvalid, rready, inst_valid}
  localparam logic [3:0] F_UPD = 4'b1000, F_ADDR = 4'b0100, F_DATA = 4'b0010,
                         F_HOLD = 4'b0001, F_ERR = 4'b0000;
  localparam logic [1:0] OK = 2'b00, SLVERR = 2'b10;

  typedef struct {
    logic        ar, rv, ir, rd;
    logic [31:0] rdata, rpc;
    logic [1:0]  resp;
    logic [3:0]  flags;
    logic [31:0] val, ipc;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(input logic ar, input logic rv, input logic [31:0] rd_data,
                              input logic [1:0] resp, input logic ir, input logic rd,
                              input logic [31:0] rpc, input logic [3:0] flags,
                              input logic [31:0] val, input logic [31:0] ipc, input logic err);
    vec_t v;
    v.ar = ar; v.rv = rv; v.rdata = rd_data; v.resp = resp; v.ir = ir; v.rd = rd;
    v.rpc = rpc; v.flags = flags; v.val = val; v.ipc = ipc; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: called at a negedge, drives inputs, checks, then advances one cycle
  task automatic apply(input int idx, input vec_t v);
    arready = v.ar; rvalid = v.rv; rdata = v.rdata; rresp = v.resp;
    inst_ready = v.ir; redirect_valid = v.rd; redirect_pc = v.rpc;
    #1;
    chk($sformatf("row%0d flags", idx), 32'({pc_wen, arvalid, rready, inst_valid}), 32'(v.flags));
    chk($sformatf("row%0d fetch_err", idx), 32'(fetch_err), 32'(v.err));
    if (v.flags[3]) chk($sformatf("row%0d next_pc", idx), next_pc, v.val);
    if (v.flags[2]) chk($sformatf("row%0d araddr", idx), araddr, v.val);
    if (v.flags[0]) begin
      chk($sformatf("row%0d inst", idx), inst, v.val);
      chk($sformatf("row%0d inst_pc", idx), inst_pc, v.ipc);
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    arready = 0; rvalid = 0; rdata = '0; rresp = OK;
    inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
  endtask

  initial begin
    logic [31:0] exp_fetch, exp_stall;

    // zero-wait fetch of the first instruction
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0000, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0000, 32'h0, 0);
    row(0,1,32'h0000_0013,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(0,0,32'h0,OK,1,0,32'h0, F_HOLD, 32'h0000_0013, 32'h8000_0000, 0);
    // wait states on both channels, then a 5-cycle IDU stall
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0004, 32'h0, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0004, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0004, 32'h0, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(0,1,32'hDEAD_BEEF,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    for (int i = 0; i < 5; i++)
      row(0,0,32'h0,OK,0,0,32'h0, F_HOLD, 32'hDEAD_BEEF, 32'h8000_0004, 0);
    row(0,0,32'h0,OK,1,0,32'h0, F_HOLD, 32'hDEAD_BEEF, 32'h8000_0004, 0);
    // redirect while waiting for data: response dropped
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0008, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0008, 32'h0, 0);
    row(0,0,32'h0,OK,0,1,32'h8000_0100, F_DATA, 32'h0, 32'h0, 0);
    row(0,1,32'h1111_1111,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0100, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0100, 32'h0, 0);
    row(0,1,32'h2222_2222,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    // redirect in HOLD together with inst_ready
    row(0,0,32'h0,OK,1,1,32'h8000_0200, F_HOLD, 32'h2222_2222, 32'h8000_0100, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0200, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0200, 32'h0, 0);
    row(0,1,32'h3333_3333,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    // redirect in HOLD without inst_ready: instruction dropped
    row(0,0,32'h0,OK,0,1,32'h8000_0300, F_HOLD, 32'h3333_3333, 32'h8000_0200, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0300, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0300, 32'h0, 0);
    row(0,1,32'h4444_4444,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(0,0,32'h0,OK,1,0,32'h0, F_HOLD, 32'h4444_4444, 32'h8000_0300, 0);
    // arready delayed 3 cycles with a redirect inside the window
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0304, 32'h0, 0);
    row(0,0,32'h0,OK,0,1,32'h8000_0400, F_ADDR, 32'h8000_0304, 32'h0, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0304, 32'h0, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0304, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0304, 32'h0, 0);
    row(0,1,32'h5555_5555,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(0,0,32'h0,OK,0,0,32'h0, F_UPD, 32'h8000_0400, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0400, 32'h0, 0);
    row(0,1,32'h6666_6666,OK,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(0,0,32'h0,OK,1,0,32'h0, F_HOLD, 32'h6666_6666, 32'h8000_0400, 0);
    // redirect arriving in UPD itself
    row(0,0,32'h0,OK,0,1,32'h8000_0500, F_UPD, 32'h8000_0500, 32'h0, 0);
    row(1,0,32'h0,OK,0,0,32'h0, F_ADDR, 32'h8000_0500, 32'h0, 0);
    // error response, then ERR ignores all inputs
    row(0,1,32'h7777_7777,SLVERR,0,0,32'h0, F_DATA, 32'h0, 32'h0, 0);
    row(1,1,32'h0,OK,1,0,32'h0, F_ERR, 32'h0, 32'h0, 1);
    row(1,1,32'h0,OK,1,1,32'h8000_0600, F_ERR, 32'h0, 32'h0, 1);
    row(1,1,32'h0,OK,1,0,32'h0, F_ERR, 32'h0, 32'h0, 1);

    // reset state
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst arvalid", 32'(arvalid), 32'h0);
    chk("rst rready", 32'(rready), 32'h0);
    chk("rst inst_valid", 32'(inst_valid), 32'h0);
    chk("rst fetch_err", 32'(fetch_err), 32'h0);
    chk("rst inst", inst, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h0);
    chk("rst fetch_cnt", fetch_cnt, 32'h0);
    chk("rst stall_cnt", stall_cnt, 32'h0);
    chk("rst state", 32'(dbg_state), 32'(ST_UPD));
    reset = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

`ifdef YSYX_23060208_FETCH_PERF_EN
    exp_fetch = 32'd5;
    exp_stall = 32'd6;
`else
    exp_fetch = 32'd0;
    exp_stall = 32'd0;
`endif
    chk("fetch_cnt", fetch_cnt, exp_fetch);
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("err state", 32'(dbg_state), 32'(ST_ERR));

    // reset leaves ERR and restarts at UPD
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rec fetch_err", 32'(fetch_err), 32'h0);
    chk("rec fetch_cnt", fetch_cnt, 32'h0);
    chk("rec pc_wen", 32'(pc_wen), 32'h1);
    chk("rec next_pc", next_pc, 32'h8000_0000);
    @(negedge clock);
    arready = 1'b1;
    #1;
    chk("rec araddr", araddr, 32'h8000_0000);

    // reset while a response is arriving: it must be ignored
    @(negedge clock);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h9999_9999;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; rvalid = 1'b0;
    #1;
    chk("mid inst_valid", 32'(inst_valid), 32'h0);
    chk("mid inst", inst, 32'h0);
    chk("mid pc_wen", 32'(pc_wen), 32'h1);
    chk("mid next_pc", next_pc, 32'h8000_0000);
    @(negedge clock);
    #1;
    chk("mid arvalid", 32'(arvalid), 32'h1);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
